// File: rtl/tiny_yolo_pkg.sv
// Shared types and helpers for the tiny-YOLO activation datapath.
package tiny_yolo_pkg;

  // Largest image width any stage of the pipeline has to handle.
  localparam int MAX_IMG_W = 416;

  // One activation channel: saturated signed int8 from the requantizer.
  typedef logic signed [7:0] act_t;

  // Signed max of two activations; both operands are signed, so the compare is signed.
  function automatic act_t act_max(input act_t a, input act_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port RAM with a registered read and no reset, shaped to map onto block RAM.
module line_buffer_ram #(
  parameter int DEPTH = 208,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: contents are never reset, they are always written before being read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: one-cycle latency, the last read word is held until the next read.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pool over a raster-order stream of signed int8 activations.
// Even rows leave their horizontal pair maxima in a half-width line buffer;
// odd rows combine their own pair maxima with the buffered ones to emit a pixel.
module maxpool2x2_stream
  import tiny_yolo_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int MAX_WIDTH = MAX_IMG_W,
  parameter int DIM_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   img_width,
  input  logic [DIM_W-1:0]   img_height,
  input  logic [8*LANES-1:0] data_in,
  input  logic               valid_in,
  output logic [8*LANES-1:0] data_out,
  output logic               valid_out,
  output logic               busy,
  output logic               frame_done
);

  localparam int DEPTH = MAX_WIDTH / 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 8 * LANES;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q;
  logic [DIM_W-1:0] width_q, height_q;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [PW-1:0]    pair_q;
  logic [PW-1:0]    data_out_q;
  logic             valid_out_q;
  logic             frame_done_q;

  logic             accept;
  logic             col_last, row_last;
  logic             buf_we, buf_re;
  logic [AW-1:0]    buf_addr;
  logic [PW-1:0]    buf_rdata;
  logic [PW-1:0]    h_max;
  logic [PW-1:0]    pool_max;

  assign accept   = (state_q == S_RUN) && valid_in;
  assign col_last = (col_q == width_q - DIM_W'(1));
  assign row_last = (row_q == height_q - DIM_W'(1));

  // Writes happen only on even rows and reads only on odd rows, so the ports never collide.
  assign buf_we   = accept && col_q[0] && !row_q[0];
  assign buf_re   = accept && !col_q[0] && row_q[0];
  assign buf_addr = col_q[AW:1];

  line_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PW),
    .AW    (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (h_max),
    .re    (buf_re),
    .raddr (buf_addr),
    .rdata (buf_rdata)
  );

  // Per-lane max trees: horizontal pair max, then vertical max against the buffered row.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    always_comb begin
      h_max[gi*8 +: 8]    = act_max(act_t'(pair_q[gi*8 +: 8]), act_t'(data_in[gi*8 +: 8]));
      pool_max[gi*8 +: 8] = act_max(act_t'(h_max[gi*8 +: 8]), act_t'(buf_rdata[gi*8 +: 8]));
    end
  end

  // Raster position after the current beat: column wraps at the row end.
  always_comb begin
    col_d = col_q + DIM_W'(1);
    row_d = row_q;
    if (col_last) begin
      col_d = '0;
      row_d = row_q + DIM_W'(1);
    end
  end

  // Control FSM, counters, pair register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            width_q  <= img_width;
            height_q <= img_height;
            col_q    <= '0;
            row_q    <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            if (!col_q[0]) begin
              pair_q <= data_in;
            end else if (row_q[0]) begin
              data_out_q  <= pool_max;
              valid_out_q <= 1'b1;
            end
            if (col_last && row_last) begin
              frame_done_q <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign busy       = (state_q == S_RUN);
  assign frame_done = frame_done_q;

endmodule
